seg_scan_driver: RTL and testbench

//  Parametrised time-multiplexed 7-segment scanner for N_DIG common-anode digits on the 50 MHz board clock.

---
 rtl/seg_scan_driver.sv | 213 +++++++++++++++++++++
 tb/tb_seg_scan_driver.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seg_scan_driver
//
// Time-multiplexed scanner for N_DIG common-anode 7-segment digits. Each digit
// gets one slot of DIV = CLK_HZ/SCAN_HZ clock cycles. The first BLANK_CYC
// cycles of a slot are all-off so that the previous digit's segments cannot
// ghost onto the next digit while the drivers switch over.
//
// The display reads a shadow copy of data/dot_in/dig_mask. The shadow is
// refreshed only once per frame (on the first clock after reset release and on
// the last-digit -> digit-0 wrap), so a frame never mixes old and new values.
//
// Optional feature macro: SEG_LZB_EN
//   defined   : leading-zero blanking on the shadow snapshot. Zero (or masked)
//               digits from N_DIG-1 downward are blanked until the first
//               nonzero enabled digit; digit 0 is never blanked; the dot of a
//               blanked digit is still shown.
//   undefined : every digit is decoded as-is (zero shows as 7'h01).
//
// Ports
//   FPGA_CLK        in   1        system clock, rising edge
//   RST_N           in   1        synchronous reset, active-low
//   data            in   4*N_DIG  one nibble per digit, data[3:0] = digit 0
//   dot_in          in   N_DIG    1 = light that digit's dot
//   dig_mask        in   N_DIG    1 = digit enabled, 0 = dark for its slot
//   segment         out  7        active-low segments, bit6 = a .. bit0 = g
//   seg_enable_num  out  N_DIG    active-low digit enables, one-hot-low when lit
//   dot             out  1        active-low dot
//   frame_tick      out  1        one-cycle pulse when the shadow is reloaded
// -----------------------------------------------------------------------------
module seg_scan_driver #(
    parameter int N_DIG     = 4,
    parameter int CLK_HZ    = 50_000_000,
    parameter int SCAN_HZ   = 1000,
    parameter int BLANK_CYC = 500
) (
    input  logic                 FPGA_CLK,
    input  logic                 RST_N,
    input  logic [4*N_DIG-1:0]   data,
    input  logic [N_DIG-1:0]     dot_in,
    input  logic [N_DIG-1:0]     dig_mask,
    output logic [6:0]           segment,
    output logic [N_DIG-1:0]     seg_enable_num,
    output logic                 dot,
    output logic                 frame_tick
);

    localparam int DIV   = CLK_HZ / SCAN_HZ;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIG - 1);
    localparam bit               HAS_BLANK  = (BLANK_CYC > 0);

    localparam logic [6:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    // With no blanking gap the scanner lives permanently in ST_ON.
    localparam state_t ST_RESET = HAS_BLANK ? ST_BLANK : ST_ON;

    // Hex to active-low a..g pattern.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h01;
            4'h1: pat = 7'h4F;
            4'h2: pat = 7'h12;
            4'h3: pat = 7'h06;
            4'h4: pat = 7'h4C;
            4'h5: pat = 7'h24;
            4'h6: pat = 7'h20;
            4'h7: pat = 7'h0F;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h04;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h60;
            4'hC: pat = 7'h31;
            4'hD: pat = 7'h42;
            4'hE: pat = 7'h30;
            default: pat = 7'h38;
        endcase
        return pat;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_load_pend;
    logic [4*N_DIG-1:0]   r_sh_data;
    logic [N_DIG-1:0]     r_sh_dot;
    logic [N_DIG-1:0]     r_sh_mask;

    // ------------------------------------------------------------------
    // Slot decode from the shadow snapshot
    // ------------------------------------------------------------------
    logic                 w_slot_end;
    logic                 w_frame_end;
    logic                 w_load;
    logic [3:0]           w_nib;
    logic                 w_dig_on;
    logic                 w_dig_dot;
    logic [6:0]           w_seg;
    logic [N_DIG-1:0]     w_en_lit;

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == IDX_LAST);
    assign w_load      = r_load_pend || w_frame_end;

    assign w_nib     = r_sh_data[{r_idx, 2'b00} +: 4];
    assign w_dig_on  = r_sh_mask[r_idx];
    assign w_dig_dot = r_sh_dot[r_idx];

    // NOTE: give every always_comb output a default before any conditional
    // write, otherwise the unassigned paths infer a latch.
    always_comb begin
        w_en_lit        = '1;
        w_en_lit[r_idx] = 1'b0;
    end

`ifdef SEG_LZB_EN
    // w_lead_zero[i] is set while digits N_DIG-1..i are all zero or masked.
    // Bit 0 stays clear so the units digit always shows.
    logic [N_DIG-1:0] w_lead_zero;

    always_comb begin
        logic run;
        run         = 1'b1;
        w_lead_zero = '0;
        for (int i = N_DIG - 1; i > 0; i--) begin
            run            = run & ((r_sh_data[4*i +: 4] == 4'h0) | ~r_sh_mask[i]);
            w_lead_zero[i] = run;
        end
    end

    assign w_seg = w_lead_zero[r_idx] ? SEG_OFF : seg_decode(w_nib);
`else
    assign w_seg = seg_decode(w_nib);
`endif

    // ------------------------------------------------------------------
    // Scan FSM, snapshot and registered pin drivers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the value from before this clock edge.
    always_ff @(posedge FPGA_CLK) begin
        if (!RST_N) begin
            r_state        <= ST_RESET;
            r_cnt          <= '0;
            r_idx          <= '0;
            r_load_pend    <= 1'b1;
            // NOTE: the shadow is a handful of flops, not a RAM, so clearing
            // it costs nothing and keeps the first frame deterministic.
            r_sh_data      <= '0;
            r_sh_dot       <= '0;
            r_sh_mask      <= '0;
            segment        <= SEG_OFF;
            seg_enable_num <= '1;
            dot            <= 1'b1;
            frame_tick     <= 1'b0;
        end else begin
            r_cnt <= w_slot_end ? '0 : r_cnt + 1'b1;

            // A masked digit still consumes its slot, so brightness stays
            // uniform regardless of how many digits are enabled.
            if (w_slot_end) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end

            case (r_state)
                ST_BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        r_state <= ST_ON;
                    end
                end
                default: begin
                    if (w_slot_end && HAS_BLANK) begin
                        r_state <= ST_BLANK;
                    end
                end
            endcase

            // Snapshot on the first cycle after reset and at each frame wrap.
            r_load_pend <= 1'b0;
            frame_tick  <= w_load;
            if (w_load) begin
                r_sh_data <= data;
                r_sh_dot  <= dot_in;
                r_sh_mask <= dig_mask;
            end

            // Pins follow the current state/idx one cycle later.
            if (r_state == ST_ON) begin
                segment        <= w_seg;
                seg_enable_num <= w_dig_on ? w_en_lit : '1;
                dot            <= ~w_dig_dot;
            end else begin
                segment        <= SEG_OFF;
                seg_enable_num <= '1;
                dot            <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_driver
//
// Two scanners share one set of inputs: u_dut with a 2-cycle blanking gap and
// u_dut_nb with no gap. Both use DIV = 10 and N_DIG = 4, so their slot counters
// and frame ticks run in lockstep and a 40-cycle frame can be described once.
// Expected pin values come from a table of per-digit segment constants.
// -----------------------------------------------------------------------------
module tb_seg_scan_driver;

    localparam int N_DIG = 4;
    localparam int DIV   = 10;
    localparam int BLANK = 2;
    localparam int FRAME = N_DIG * DIV;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dot_in = '0;
    logic [3:0]  dig_mask = '0;

    logic [6:0]  a_seg, b_seg;
    logic [3:0]  a_en, b_en;
    logic        a_dot, b_dot;
    logic        a_tick, b_tick;

    always #5 clk = ~clk;

    seg_scan_driver #(
        .N_DIG(N_DIG), .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(BLANK)
    ) u_dut (
        .FPGA_CLK(clk), .RST_N(rst_n), .data(data), .dot_in(dot_in),
        .dig_mask(dig_mask), .segment(a_seg), .seg_enable_num(a_en),
        .dot(a_dot), .frame_tick(a_tick)
    );

    seg_scan_driver #(
        .N_DIG(N_DIG), .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(0)
    ) u_dut_nb (
        .FPGA_CLK(clk), .RST_N(rst_n), .data(data), .dot_in(dot_in),
        .dig_mask(dig_mask), .segment(b_seg), .seg_enable_num(b_en),
        .dot(b_dot), .frame_tick(b_tick)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] en;
        logic       dot;
        logic       tick;
    } obs_t;

    typedef struct packed {
        obs_t a;
        obs_t b;
    } exp_t;

    // seg = {digit3, digit2, digit1, digit0} expected segment patterns.
    typedef struct packed {
        logic [15:0]     data;
        logic [3:0]      dot;
        logic [3:0]      mask;
        logic [3:0][6:0] seg;
    } vec_t;

    vec_t vecs[8];
    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    function automatic obs_t dark_obs(input logic tick);
        obs_t o;
        o.seg  = 7'h7F;
        o.en   = 4'hF;
        o.dot  = 1'b1;
        o.tick = tick;
        return o;
    endfunction

    function automatic obs_t lit_obs(input vec_t v, input int s, input logic tick);
        obs_t o;
        o.seg  = v.seg[s];
        o.en   = v.mask[s] ? ~(4'b0001 << s) : 4'hF;
        o.dot  = ~v.dot[s];
        o.tick = tick;
        return o;
    endfunction

    function automatic obs_t obs_a();
        return {a_seg, a_en, a_dot, a_tick};
    endfunction

    function automatic obs_t obs_b();
        return {b_seg, b_en, b_dot, b_tick};
    endfunction

    task automatic check(input string name, input int k, input obs_t act, input obs_t want);
        n_vec++;
        if (act !== want) begin
            n_miss++;
            $display("FAIL %s k=%0d: got seg=%02h en=%h dot=%b tick=%b, want seg=%02h en=%h dot=%b tick=%b",
                     name, k, act.seg, act.en, act.dot, act.tick,
                     want.seg, want.en, want.dot, want.tick);
        end
    endtask

    task automatic drive(input vec_t v);
        data     = v.data;
        dot_in   = v.dot;
        dig_mask = v.mask;
    endtask

    // Compare the sample at the current negedge against the queue head.
    task automatic pop_compare(input string name, input int k);
        exp_t e;
        e = sb.pop_front();
        check({name, "_gap"},   k, obs_a(), e.a);
        check({name, "_nogap"}, k, obs_b(), e.b);
    endtask

    // Advance to the next negedge on which frame_tick is high.
    task automatic sync_tick();
        for (int i = 0; i < FRAME + 20; i++) begin
            @(negedge clk);
            if (a_tick) return;
        end
        n_vec++;
        n_miss++;
        $display("FAIL sync_tick: no frame_tick within %0d cycles", FRAME + 20);
    endtask

    // One steady-state frame. k counts cycles after the frame_tick cycle;
    // with the gap, cycles 1,2 of each 10 are dark. If chg_k > 0 the data
    // input is changed mid-frame, which must not reach the pins.
    task automatic run_frame(input string name, input vec_t v, input int chg_k,
                             input logic [15:0] chg_data);
        exp_t e;
        for (int k = 1; k <= FRAME; k++) begin
            int pos;
            int s;
            pos = (k - 1) % DIV;
            s   = (k - 1) / DIV;
            e.a = (pos < BLANK) ? dark_obs(k == FRAME) : lit_obs(v, s, k == FRAME);
            e.b = lit_obs(v, s, k == FRAME);
            sb.push_back(e);
        end
        for (int k = 1; k <= FRAME; k++) begin
            @(negedge clk);
            if (k == chg_k) data = chg_data;
            pop_compare(name, k);
        end
    endtask

    // Hold reset 3 cycles, release, then follow the first slot. Reset drives
    // all pins dark; the first cycle after release loads the snapshot. The
    // no-gap scanner shows digit 0 at once, from the still-cleared shadow.
    task automatic reset_startup(input string name, input vec_t v);
        exp_t e;
        rst_n = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            e.a = dark_obs(1'b0);
            e.b = dark_obs(1'b0);
            sb.push_back(e);
            @(negedge clk);
            pop_compare({name, "_rst"}, n);
        end
        rst_n = 1'b1;
        for (int n = 1; n <= DIV; n++) begin
            e.a = (n <= BLANK) ? dark_obs(n == 1) : lit_obs(v, 0, 1'b0);
            if (n == 1) begin
                e.b.seg  = 7'h01;
                e.b.en   = 4'hF;
                e.b.dot  = 1'b1;
                e.b.tick = 1'b1;
            end else begin
                e.b = lit_obs(v, 0, 1'b0);
            end
            sb.push_back(e);
            @(negedge clk);
            pop_compare({name, "_start"}, n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{data: 16'h3A51, dot: 4'b0000, mask: 4'b1111,
                    seg: {7'h06, 7'h08, 7'h24, 7'h4F}};
        vecs[4] = '{data: 16'h89EF, dot: 4'b0000, mask: 4'b1111,
                    seg: {7'h00, 7'h04, 7'h30, 7'h38}};
        vecs[5] = '{data: 16'hBCD2, dot: 4'b1111, mask: 4'b1010,
                    seg: {7'h60, 7'h31, 7'h42, 7'h12}};
        vecs[6] = '{data: 16'h4676, dot: 4'b0000, mask: 4'b1111,
                    seg: {7'h4C, 7'h20, 7'h0F, 7'h20}};
`ifdef SEG_LZB_EN
        vecs[1] = '{data: 16'h3A51, dot: 4'b0100, mask: 4'b0101,
                    seg: {7'h7F, 7'h08, 7'h24, 7'h4F}};
        vecs[2] = '{data: 16'h0070, dot: 4'b0000, mask: 4'b1111,
                    seg: {7'h7F, 7'h7F, 7'h0F, 7'h01}};
        vecs[3] = '{data: 16'h0000, dot: 4'b1000, mask: 4'b1111,
                    seg: {7'h7F, 7'h7F, 7'h7F, 7'h01}};
        vecs[7] = '{data: 16'h0000, dot: 4'b0000, mask: 4'b1111,
                    seg: {7'h7F, 7'h7F, 7'h7F, 7'h01}};
`else
        vecs[1] = '{data: 16'h3A51, dot: 4'b0100, mask: 4'b0101,
                    seg: {7'h06, 7'h08, 7'h24, 7'h4F}};
        vecs[2] = '{data: 16'h0070, dot: 4'b0000, mask: 4'b1111,
                    seg: {7'h01, 7'h01, 7'h0F, 7'h01}};
        vecs[3] = '{data: 16'h0000, dot: 4'b1000, mask: 4'b1111,
                    seg: {7'h01, 7'h01, 7'h01, 7'h01}};
        vecs[7] = '{data: 16'h0000, dot: 4'b0000, mask: 4'b1111,
                    seg: {7'h01, 7'h01, 7'h01, 7'h01}};
`endif

        // Power-up reset and first slot.
        drive(vecs[0]);
        reset_startup("por", vecs[0]);

        // Table: each vector is picked up by the next snapshot.
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i]);
            sync_tick();
            run_frame($sformatf("vec%0d", i), vecs[i], 0, 16'h0000);
        end

        // Change data during digit 1's slot: the frame in flight keeps the old
        // snapshot, the very next frame shows the new value.
        drive(vecs[0]);
        sync_tick();
        run_frame("tear_old", vecs[0], 15, 16'h0000);
        run_frame("tear_new", vecs[7], 0, 16'h0000);

        // Reset in the middle of a slot restarts at digit 0 with a new snapshot.
        drive(vecs[4]);
        repeat (13) @(negedge clk);
        reset_startup("midrst", vecs[4]);
        sync_tick();
        run_frame("after_rst", vecs[4], 0, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
